// File: rtl/csr_pkg.sv
// ============================================================================
// Module      : csr_pkg
// Description : CSR address map, funct3 encoding and mcountinhibit bit indices
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [11:0] c_csr_cycle         = 12'hC00;
    localparam logic [11:0] c_csr_instret       = 12'hC02;
    localparam logic [11:0] c_csr_cycleh        = 12'hC80;
    localparam logic [11:0] c_csr_instreth      = 12'hC82;
    localparam logic [11:0] c_csr_mcycle        = 12'hB00;
    localparam logic [11:0] c_csr_minstret      = 12'hB02;
    localparam logic [11:0] c_csr_mcycleh       = 12'hB80;
    localparam logic [11:0] c_csr_minstreth     = 12'hB82;
    localparam logic [11:0] c_csr_mcountinhibit = 12'h320;
    localparam logic [11:0] c_csr_mscratch      = 12'h340;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } funct3_e;

    localparam int c_inh_cy   = 0;
    localparam int c_inh_tm   = 1;
    localparam int c_inh_ir   = 2;
    localparam int c_inh_hpm3 = 3;

endpackage

`default_nettype wire

// File: rtl/csr_counter.sv
// ============================================================================
// Module      : csr_counter
// Description : One wide event counter with inhibit and 32-bit half writes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_counter #(
    parameter int CNT_WIDTH = 64,
    parameter int INC_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INC_W-1:0]     inc,
    input  logic                 inhibit,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wr_data,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // A software write to either half takes priority over this cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_count[31:0]           <= wr_data;
            if (wr_hi) r_count[CNT_WIDTH-1:32] <= wr_data[CNT_WIDTH-33:0];
        end else if (!inhibit) begin
            r_count <= r_count + CNT_WIDTH'(inc);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/csr_file.sv
// ============================================================================
// Module      : csr_file
// Description : Counter/timer CSRs, mcountinhibit and mscratch with Zicsr ops
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file
    import csr_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4,
    parameter int RETIRE_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_valid,
    input  logic                stall,
    input  logic [2:0]          function_3,
    input  logic [11:0]         csr_addr,
    input  logic [4:0]          rs1_addr,
    input  logic [XLEN-1:0]     rs1,
    input  logic [RETIRE_W-1:0] retire_cnt,
    input  logic [NUM_HPM-1:0]  hpm_event,
    output logic [XLEN-1:0]     csr_rd_data,
    output logic                csr_illegal
);

    localparam int NUM_CNT = 2 + NUM_HPM;
    localparam logic [31:0] c_inh_mask =
        32'((64'd1 << (NUM_HPM + c_inh_hpm3)) - 64'd1) & ~(32'd1 << c_inh_tm);

    logic [CNT_WIDTH-1:0] w_cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   w_wr_lo;
    logic [NUM_CNT-1:0]   w_wr_hi;
    logic [31:0]          r_inhibit;
    logic [XLEN-1:0]      r_mscratch;

    logic                 w_cnt_user;
    logic                 w_cnt_mach;
    logic                 w_n_ok;
    logic                 w_hi;
    logic [4:0]           w_n;
    logic [4:0]           w_k;
    logic [CNT_WIDTH-1:0] w_sel;
    logic                 w_mapped;
    logic                 w_user;
    logic [XLEN-1:0]      w_old;
    logic [XLEN-1:0]      w_op;
    logic [XLEN-1:0]      w_new;
    logic                 w_f3_ok;
    logic                 w_wr_try;
    logic                 w_commit;

    // Counter CSRs occupy 0xC00/0xC80 (user) and 0xB00/0xB80 (machine) + N.
    assign w_n        = csr_addr[4:0];
    assign w_hi       = csr_addr[7];
    assign w_cnt_user = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);
    assign w_cnt_mach = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
    assign w_n_ok     = (w_n == 5'd0) || (w_n == 5'd2) ||
                        ((w_n >= 5'd3) && (int'(w_n) < c_inh_hpm3 + NUM_HPM));
    // Counter slot: 0 = cycle, 1 = instret, 2.. = hpmcounter3..
    assign w_k        = (w_n == 5'd0) ? 5'd0 : (w_n == 5'd2) ? 5'd1 : w_n - 5'd1;

    always_comb begin
        w_sel    = '0;
        w_mapped = 1'b0;
        w_user   = 1'b0;
        w_old    = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (w_k == 5'(k)) w_sel = w_cnt[k];
        end
        if ((w_cnt_user || w_cnt_mach) && w_n_ok) begin
            w_mapped = 1'b1;
            w_user   = w_cnt_user;
            w_old    = w_hi ? XLEN'(w_sel[CNT_WIDTH-1:32]) : XLEN'(w_sel[31:0]);
        end else if (csr_addr == c_csr_mcountinhibit) begin
            w_mapped = 1'b1;
            w_old    = XLEN'(r_inhibit);
        end else if (csr_addr == c_csr_mscratch) begin
            w_mapped = 1'b1;
            w_old    = r_mscratch;
        end
    end

    assign w_op = function_3[2] ? XLEN'(rs1_addr) : rs1;

    always_comb begin
        w_new   = w_old;
        w_f3_ok = 1'b1;
        case (funct3_e'(function_3))
            F3_RW, F3_RWI: w_new = w_op;
            F3_RS, F3_RSI: w_new = w_old | w_op;
            F3_RC, F3_RCI: w_new = w_old & ~w_op;
            default:       w_f3_ok = 1'b0;
        endcase
    end

    // Set/clear with a zero source field is a pure read and never a write.
    assign w_wr_try    = (function_3[1:0] == 2'b01) || (rs1_addr != 5'd0);
    assign csr_illegal = csr_valid && (!w_mapped || !w_f3_ok || (w_wr_try && w_user));
    assign w_commit    = csr_valid && !stall && !csr_illegal && w_wr_try;
    assign csr_rd_data = (csr_valid && !csr_illegal) ? w_old : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inhibit  <= '0;
            r_mscratch <= '0;
        end else if (w_commit) begin
            if (csr_addr == c_csr_mcountinhibit) r_inhibit  <= w_new[31:0] & c_inh_mask;
            if (csr_addr == c_csr_mscratch)      r_mscratch <= w_new;
        end
    end

    generate
        for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
            logic [RETIRE_W-1:0] w_inc;
            logic                w_inh;

            if (k == 0) begin : g_cycle
                assign w_inc = RETIRE_W'(1);
                assign w_inh = r_inhibit[c_inh_cy];
            end else if (k == 1) begin : g_instret
                assign w_inc = retire_cnt;
                assign w_inh = r_inhibit[c_inh_ir];
            end else begin : g_hpm
                assign w_inc = RETIRE_W'(hpm_event[k-2]);
                assign w_inh = r_inhibit[k+1];
            end

            assign w_wr_lo[k] = w_commit && w_cnt_mach && w_n_ok && !w_hi && (w_k == 5'(k));
            assign w_wr_hi[k] = w_commit && w_cnt_mach && w_n_ok &&  w_hi && (w_k == 5'(k));

            csr_counter #(
                .CNT_WIDTH (CNT_WIDTH),
                .INC_W     (RETIRE_W)
            ) u_counter (
                .clk     (clk),
                .rst     (rst),
                .inc     (w_inc),
                .inhibit (w_inh),
                .wr_lo   (w_wr_lo[k]),
                .wr_hi   (w_wr_hi[k]),
                .wr_data (w_new[31:0]),
                .count   (w_cnt[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
// Module      : tb_csr_file
// Description : Directed self-checking bench for csr_file with reference model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_file;

    localparam int NUM_HPM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  function_3 = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [4:0]  rs1_addr = 5'd0;
    logic [31:0] rs1 = 32'd0;
    logic [1:0]  retire_cnt = 2'd0;
    logic [3:0]  hpm_event = 4'd0;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_file #(
        .XLEN      (32),
        .CNT_WIDTH (64),
        .NUM_HPM   (NUM_HPM),
        .RETIRE_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_valid   (csr_valid),
        .stall       (stall),
        .function_3  (function_3),
        .csr_addr    (csr_addr),
        .rs1_addr    (rs1_addr),
        .rs1         (rs1),
        .retire_cnt  (retire_cnt),
        .hpm_event   (hpm_event),
        .csr_rd_data (csr_rd_data),
        .csr_illegal (csr_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters indexed by their architectural number N.
    longint unsigned m_cnt [32];
    bit [31:0]       m_inh;
    bit [31:0]       m_scr;

    function automatic bit legal_n(input int n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
    endfunction

    function automatic bit [31:0] inh_mask();
        bit [31:0] m = 32'd0;
        for (int i = 0; i < 32; i++) if (legal_n(i)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic void decode(input logic [11:0] a, output int kind, output int n,
                                   output bit hi, output bit user);
        int bases [4];
        bases = '{32'hC00, 32'hC80, 32'hB00, 32'hB80};
        kind = 0; n = 0; hi = 1'b0; user = 1'b0;
        if (a == 12'h320) kind = 2;
        else if (a == 12'h340) kind = 3;
        else begin
            for (int b = 0; b < 4; b++) begin
                if (int'(a) >= bases[b] && int'(a) < bases[b] + 32) begin
                    n    = int'(a) - bases[b];
                    hi   = (b % 2) == 1;
                    user = b < 2;
                    if (legal_n(n)) kind = 1;
                end
            end
        end
    endfunction

    function automatic void model_eval(output bit ill, output logic [31:0] rd, output bit wr,
                                       output logic [31:0] nv, output int kind, output int n,
                                       output bit hi);
        bit          user;
        bit          attempt;
        logic [31:0] op;
        logic [31:0] old;
        decode(csr_addr, kind, n, hi, user);
        case (kind)
            1:       old = hi ? 32'(m_cnt[n] >> 32) : 32'(m_cnt[n]);
            2:       old = m_inh;
            3:       old = m_scr;
            default: old = 32'd0;
        endcase
        op      = function_3[2] ? {27'd0, rs1_addr} : rs1;
        attempt = (function_3[1:0] == 2'b01) || (rs1_addr != 5'd0);
        ill     = csr_valid && (kind == 0 || function_3[1:0] == 2'b00 || (attempt && user));
        rd      = (csr_valid && !ill) ? old : 32'd0;
        case (function_3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = old;
        endcase
        wr = csr_valid && !stall && !ill && attempt;
    endfunction

    bit          u_ill, u_wr, u_hi;
    logic [31:0] u_rd, u_nv;
    int          u_kind, u_n;
    longint unsigned u_inc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] <= 64'd0;
            m_inh <= 32'd0;
            m_scr <= 32'd0;
        end else begin
            model_eval(u_ill, u_rd, u_wr, u_nv, u_kind, u_n, u_hi);
            for (int i = 0; i < 32; i++) begin
                if (legal_n(i)) begin
                    if (i == 0)      u_inc = 1;
                    else if (i == 2) u_inc = longint'(retire_cnt);
                    else             u_inc = longint'(hpm_event[i-3]);
                    if (u_wr && u_kind == 1 && u_n == i)
                        m_cnt[i] <= u_hi ? {u_nv, m_cnt[i][31:0]} : {m_cnt[i][63:32], u_nv};
                    else if (!m_inh[i])
                        m_cnt[i] <= m_cnt[i] + u_inc;
                end
            end
            if (u_wr && u_kind == 2) m_inh <= u_nv & inh_mask();
            if (u_wr && u_kind == 3) m_scr <= u_nv;
        end
    end

    bit          c_ill, c_wr, c_hi;
    logic [31:0] c_rd, c_nv;
    int          c_kind, c_n;

    always @(negedge clk) begin
        model_eval(c_ill, c_rd, c_wr, c_nv, c_kind, c_n, c_hi);
        check("model_illegal", {63'd0, csr_illegal}, {63'd0, c_ill});
        if (csr_valid || rst) check("model_rd_data", {32'd0, csr_rd_data}, {32'd0, c_rd});
    end

    task automatic step(input bit v, input logic [2:0] f, input logic [11:0] a,
                        input logic [4:0] ra, input logic [31:0] rv, input logic [1:0] rc,
                        input bit st, input logic [3:0] he);
        @(posedge clk);
        #1;
        csr_valid = v; function_3 = f; csr_addr = a; rs1_addr = ra; rs1 = rv;
        retire_cnt = rc; stall = st; hpm_event = he;
        @(negedge clk);
    endtask

    task automatic csr_op(input logic [2:0] f, input logic [11:0] a,
                          input logic [4:0] ra, input logic [31:0] rv);
        step(1'b1, f, a, ra, rv, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic idle(input logic [1:0] rc, input logic [3:0] he);
        step(1'b0, 3'd0, 12'd0, 5'd0, 32'd0, rc, 1'b0, he);
    endtask

    task automatic expect_rd(input string name, input logic [31:0] v);
        check(name, {32'd0, csr_rd_data}, {32'd0, v});
    endtask

    task automatic expect_ill(input string name, input bit v);
        check(name, {63'd0, csr_illegal}, {63'd0, v});
    endtask

    initial begin
        @(negedge clk);
        expect_rd("reset_rd_zero", 32'd0);
        expect_ill("reset_illegal_zero", 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) idle(2'd0, 4'd0);
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_rd("cycle_after_10", 32'd10);
        csr_op(3'b010, 12'hC02, 5'd0, 32'd0);
        expect_rd("instret_idle", 32'd0);
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_ill("csrrs_c00_legal", 1'b0);
        expect_rd("csrrs_c00_value", 32'd12);
        csr_op(3'b001, 12'hC00, 5'd1, 32'd5);
        expect_ill("csrrw_c00_illegal", 1'b1);
        expect_rd("csrrw_c00_rd_zero", 32'd0);
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_rd("cycle_unchanged", 32'd14);

        csr_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
        expect_rd("mcycle_old", 32'd15);
        csr_op(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF);
        expect_rd("mcycleh_old", 32'd0);
        idle(2'd0, 4'd0);
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_rd("cycle_wrap_lo", 32'd0);
        csr_op(3'b010, 12'hC80, 5'd0, 32'd0);
        expect_rd("cycle_wrap_hi", 32'd0);

        csr_op(3'b110, 12'h320, 5'd5, 32'd0);
        for (int i = 0; i < 4; i++) idle(2'd2, 4'd0);
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_rd("cycle_frozen", 32'd3);
        csr_op(3'b010, 12'hC02, 5'd0, 32'd0);
        expect_rd("instret_frozen", 32'd0);
        csr_op(3'b111, 12'h320, 5'd5, 32'd0);
        expect_rd("inhibit_old", 32'd5);
        for (int i = 0; i < 4; i++) idle(2'd2, 4'd0);
        csr_op(3'b010, 12'hC02, 5'd0, 32'd0);
        expect_rd("instret_8", 32'd8);

        step(1'b1, 3'b001, 12'h340, 5'd1, 32'hA5A5_A5A5, 2'd0, 1'b1, 4'd0);
        csr_op(3'b010, 12'h340, 5'd0, 32'd0);
        expect_rd("mscratch_stalled", 32'd0);
        csr_op(3'b001, 12'h340, 5'd1, 32'hA5A5_A5A5);
        expect_rd("mscratch_write_old", 32'd0);
        csr_op(3'b010, 12'h340, 5'd0, 32'd0);
        expect_rd("mscratch_new", 32'hA5A5_A5A5);

        step(1'b1, 3'b001, 12'hB02, 5'd1, 32'd100, 2'd2, 1'b0, 4'd0);
        csr_op(3'b010, 12'hC02, 5'd0, 32'd0);
        expect_rd("minstret_write_wins", 32'd100);

        idle(2'd0, 4'b0001);
        idle(2'd0, 4'b0011);
        idle(2'd0, 4'b0001);
        csr_op(3'b010, 12'hC03, 5'd0, 32'd0);
        expect_rd("hpm3_count", 32'd3);
        csr_op(3'b010, 12'hB04, 5'd0, 32'd0);
        expect_rd("hpm4_count", 32'd1);

        csr_op(3'b010, 12'hC07, 5'd0, 32'd0);
        expect_ill("hpm_index_oob", 1'b1);
        csr_op(3'b010, 12'hC06, 5'd0, 32'd0);
        expect_ill("hpm_last_legal", 1'b0);
        csr_op(3'b010, 12'hC01, 5'd0, 32'd0);
        expect_ill("time_unmapped", 1'b1);
        csr_op(3'b000, 12'h340, 5'd0, 32'd0);
        expect_ill("funct3_000", 1'b1);
        csr_op(3'b100, 12'h340, 5'd0, 32'd0);
        expect_ill("funct3_100", 1'b1);

        csr_op(3'b001, 12'h320, 5'd1, 32'hFFFF_FFFF);
        csr_op(3'b010, 12'h320, 5'd0, 32'd0);
        expect_rd("inhibit_hardwired", 32'h0000_007D);
        csr_op(3'b001, 12'h320, 5'd1, 32'd0);

        csr_op(3'b001, 12'h340, 5'd1, 32'h0000_1234);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        csr_valid = 1'b0; function_3 = 3'd0; csr_addr = 12'd0; rs1_addr = 5'd0; rs1 = 32'd0;
        csr_op(3'b010, 12'hC00, 5'd0, 32'd0);
        expect_rd("cycle_one_after_reset", 32'd1);
        csr_op(3'b010, 12'h340, 5'd0, 32'd0);
        expect_rd("inflight_write_dropped", 32'd0);

        idle(2'd0, 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
